timer_controller: RTL and testbench

//  Sequencer for the cascaded counter_mod10 countdown chain (microwave-style timer).

---
 rtl/timer_controller_if.sv | 24 ++
 rtl/timer_controller.sv | 110 +++++++++++
 tb/tb_timer_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_controller_if.sv
// User controls, counter-chain drives and status for the countdown sequencer.
interface timer_controller_if;
   logic       load;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic       zero_all;
   logic       cnt_loadn;
   logic       cnt_clearn;
   logic       cnt_enable;
   logic       running;
   logic       done;
   logic [2:0] state;

   modport master (
      input  load, start, stop, door_closed, zero_all,
      output cnt_loadn, cnt_clearn, cnt_enable, running, done, state
   );

   modport slave (
      output load, start, stop, door_closed, zero_all,
      input  cnt_loadn, cnt_clearn, cnt_enable, running, done, state
   );
endinterface

// File: rtl/timer_controller.sv
// Sequencer for the cascaded digit-counter countdown chain: load/clear/tick pulses and door interlock.
// All outputs registered (one cycle after the deciding input); no backpressure, inputs sampled every cycle.
module timer_controller #(
   parameter int TICK_DIV   = 10,
   parameter int PRESCALE_W = 26
) (
   input  logic                clock,
   input  logic                clearn,
   timer_controller_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_DONE  = 3'd3
   } state_e;

   localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_DIV - 1);

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  cnt_loadn_q, cnt_loadn_d;
   logic                  cnt_clearn_q, cnt_clearn_d;
   logic                  cnt_enable_q, cnt_enable_d;
   logic                  running_q, running_d;
   logic                  done_q, done_d;

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      cnt_loadn_d  = 1'b1;
      cnt_clearn_d = 1'b1;
      cnt_enable_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.stop) begin
               cnt_clearn_d = 1'b0;
            end else if (bus.start && bus.door_closed && !bus.zero_all) begin
               state_d = S_RUN;
               presc_d = '0;
            end else if (bus.load) begin
               cnt_loadn_d = 1'b0;
            end
         end
         S_RUN: begin
            // Leaving RUN freezes the prescaler so a resume finishes the partial second.
            if (bus.stop || !bus.door_closed) begin
               state_d = S_PAUSE;
            end else if (bus.zero_all) begin
               state_d = S_DONE;
            end else if (presc_q == PRESC_LAST) begin
               presc_d      = '0;
               cnt_enable_d = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_PAUSE: begin
            if (bus.stop) begin
               state_d      = S_IDLE;
               cnt_clearn_d = 1'b0;
            end else if (bus.start && bus.door_closed) begin
               state_d = bus.zero_all ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            if (bus.stop) begin
               state_d = S_IDLE;
            end else if (bus.load) begin
               state_d     = S_IDLE;
               cnt_loadn_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         cnt_loadn_q  <= 1'b1;
         cnt_clearn_q <= 1'b1;
         cnt_enable_q <= 1'b0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         cnt_loadn_q  <= cnt_loadn_d;
         cnt_clearn_q <= cnt_clearn_d;
         cnt_enable_q <= cnt_enable_d;
         running_q    <= running_d;
         done_q       <= done_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.cnt_loadn  = cnt_loadn_q;
   assign bus.cnt_clearn = cnt_clearn_q;
   assign bus.cnt_enable = cnt_enable_q;
   assign bus.running    = running_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed and randomized bench for timer_controller with a counter-chain model and a behavioural reference.
module tb_timer_controller;
   localparam int TICK_DIV = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clock = 1'b0;
   logic clearn = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   timer_controller_if ifc ();

   timer_controller #(.TICK_DIV(TICK_DIV), .PRESCALE_W(26)) dut (
      .clock  (clock),
      .clearn (clearn),
      .bus    (ifc.master)
   );

   // Digit counter chain seen as one integer value.
   int cnt_val = 0;
   int key_val = 6;
   always @(posedge clock) begin
      if (!ifc.cnt_loadn)                     cnt_val <= key_val;
      else if (!ifc.cnt_clearn)               cnt_val <= 0;
      else if (ifc.cnt_enable && cnt_val > 0) cnt_val <= cnt_val - 1;
   end
   assign ifc.zero_all = (cnt_val == 0);

   // Reference: mode plus seconds-worth of run time accumulated since the countdown began.
   int   m_mode;
   int   m_elapsed;
   logic m_loadn, m_clearn, m_enable;
   always @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         m_mode <= M_IDLE; m_elapsed <= 0;
         m_loadn <= 1'b1; m_clearn <= 1'b1; m_enable <= 1'b0;
      end else begin : upd
         int mode_n, el_n;
         logic ln, cn, en;
         mode_n = m_mode; el_n = m_elapsed; ln = 1'b1; cn = 1'b1; en = 1'b0;
         if (m_mode == M_IDLE) begin
            if (ifc.stop) cn = 1'b0;
            else if (ifc.start && ifc.door_closed && !ifc.zero_all) begin mode_n = M_RUN; el_n = 0; end
            else if (ifc.load) ln = 1'b0;
         end else if (m_mode == M_RUN) begin
            if (ifc.stop || !ifc.door_closed) mode_n = M_PAUSE;
            else if (ifc.zero_all) mode_n = M_DONE;
            else begin
               el_n = m_elapsed + 1;
               en = ((el_n % TICK_DIV) == 0);
            end
         end else if (m_mode == M_PAUSE) begin
            if (ifc.stop) begin mode_n = M_IDLE; cn = 1'b0; end
            else if (ifc.start && ifc.door_closed) mode_n = ifc.zero_all ? M_DONE : M_RUN;
         end else begin
            if (ifc.stop) mode_n = M_IDLE;
            else if (ifc.load) begin mode_n = M_IDLE; ln = 1'b0; end
         end
         m_mode <= mode_n; m_elapsed <= el_n;
         m_loadn <= ln; m_clearn <= cn; m_enable <= en;
      end
   end

   int n_ld = 0, n_clr = 0, n_en = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("state",   32'(ifc.state), 32'(m_mode));
      chk("running", 32'(ifc.running), 32'(m_mode == M_RUN));
      chk("done",    32'(ifc.done), 32'(m_mode == M_DONE));
      chk("loadn",   32'(ifc.cnt_loadn), 32'(m_loadn));
      chk("clearn",  32'(ifc.cnt_clearn), 32'(m_clearn));
      chk("enable",  32'(ifc.cnt_enable), 32'(m_enable));
      chk("inv_ld_cl", 32'(!ifc.cnt_loadn && !ifc.cnt_clearn), 0);
      chk("inv_en", 32'(ifc.cnt_enable && (!ifc.cnt_loadn || !ifc.cnt_clearn)), 0);
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      check_all();
      if (!ifc.cnt_loadn)  n_ld++;
      if (!ifc.cnt_clearn) n_clr++;
      if (ifc.cnt_enable)  n_en++;
   endtask

   task automatic do_load(input int k);
      key_val = k;
      ifc.load = 1'b1; cyc();
      ifc.load = 1'b0; cyc();
   endtask

   task automatic wait_tick(output int t);
      t = 0;
      do begin cyc(); t++; end while (!ifc.cnt_enable && t < 3 * TICK_DIV);
   endtask

   initial begin
      int pulses, first, last, done_k, snap, t;
      ifc.load = 1'b0; ifc.start = 1'b0; ifc.stop = 1'b0; ifc.door_closed = 1'b1;
      #1 clearn = 1'b0;
      @(negedge clock);
      check_all();
      chk("rst_state", 32'(ifc.state), 0);
      chk("rst_loadn", 32'(ifc.cnt_loadn), 1);
      clearn = 1'b1;
      cyc();

      // Load 6 and count down to DONE
      key_val = 6;
      ifc.load = 1'b1; cyc();
      chk("t2_loadn_low", 32'(ifc.cnt_loadn), 0);
      ifc.load = 1'b0; cyc();
      chk("t2_loadn_back", 32'(ifc.cnt_loadn), 1);
      ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      chk("t2_run", 32'(ifc.state), M_RUN);
      pulses = 0; first = -1; last = -1; done_k = -1;
      for (int k = 1; k <= 100 && done_k < 0; k++) begin
         cyc();
         if (ifc.cnt_enable) begin pulses++; if (first < 0) first = k; last = k; end
         if (ifc.done) done_k = k;
      end
      chk("t2_pulses", pulses, 6);
      chk("t2_first", first, 10);
      chk("t2_last", last, 60);
      chk("t2_done_at", done_k, 62);
      snap = n_en;
      for (int k = 0; k < 15; k++) cyc();
      chk("t2_no_7th", n_en - snap, 0);
      chk("t2_state", 32'(ifc.state), M_DONE);
      ifc.load = 1'b1; cyc(); ifc.load = 1'b0;
      chk("done_load_idle", 32'(ifc.state), M_IDLE);
      chk("done_load_pulse", 32'(ifc.cnt_loadn), 0);
      cyc();

      // Door interlock
      ifc.door_closed = 1'b0; ifc.start = 1'b1;
      cyc(); cyc(); cyc();
      chk("t3_door_open_idle", 32'(ifc.state), M_IDLE);
      ifc.start = 1'b0; ifc.door_closed = 1'b1; cyc();
      ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      wait_tick(t);
      chk("t3_first_tick", t, 10);
      for (int k = 0; k < 4; k++) cyc();
      ifc.door_closed = 1'b0; cyc();
      chk("t3_pause", 32'(ifc.state), M_PAUSE);
      cyc(); cyc(); cyc();
      ifc.door_closed = 1'b1; ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      chk("t3_resume", 32'(ifc.state), M_RUN);
      wait_tick(t);
      chk("t3_resume_tick", t, 6);

      // Stop twice
      snap = n_clr;
      ifc.stop = 1'b1; cyc(); ifc.stop = 1'b0;
      chk("t4_pause", 32'(ifc.state), M_PAUSE);
      cyc();
      ifc.stop = 1'b1; cyc(); ifc.stop = 1'b0;
      chk("t4_idle", 32'(ifc.state), M_IDLE);
      cyc(); cyc();
      chk("t4_one_clear", n_clr - snap, 1);

      // Start with counters at zero
      ifc.start = 1'b1; cyc(); cyc(); cyc(); ifc.start = 1'b0;
      chk("t6_zero_start", 32'(ifc.state), M_IDLE);

      // start+stop together in IDLE and PAUSE
      do_load(5);
      ifc.start = 1'b1; ifc.stop = 1'b1; cyc();
      chk("t5_idle_state", 32'(ifc.state), M_IDLE);
      chk("t5_idle_clear", 32'(ifc.cnt_clearn), 0);
      ifc.start = 1'b0; ifc.stop = 1'b0; cyc();
      do_load(5);
      ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      ifc.stop = 1'b1; cyc(); ifc.stop = 1'b0;
      chk("t5_pause", 32'(ifc.state), M_PAUSE);
      ifc.start = 1'b1; ifc.stop = 1'b1; cyc();
      chk("t5_pause_state", 32'(ifc.state), M_IDLE);
      chk("t5_pause_clear", 32'(ifc.cnt_clearn), 0);
      ifc.start = 1'b0; ifc.stop = 1'b0; cyc();

      // Load ignored in RUN
      do_load(5);
      ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      snap = n_ld;
      ifc.load = 1'b1; cyc(); cyc(); cyc(); ifc.load = 1'b0;
      chk("t6_run_load", n_ld - snap, 0);
      chk("t6_run_state", 32'(ifc.state), M_RUN);

      // Async reset mid-RUN
      #2 clearn = 1'b0;
      #1;
      chk("t1_state", 32'(ifc.state), 0);
      chk("t1_running", 32'(ifc.running), 0);
      chk("t1_enable", 32'(ifc.cnt_enable), 0);
      chk("t1_loadn", 32'(ifc.cnt_loadn), 1);
      chk("t1_clearn", 32'(ifc.cnt_clearn), 1);
      @(negedge clock);
      clearn = 1'b1;
      cyc();

      // Door opens in the final tick cycle, then start from PAUSE sees zero
      do_load(1);
      ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      wait_tick(t);
      chk("ft_tick", t, 10);
      ifc.door_closed = 1'b0; cyc();
      chk("ft_pause", 32'(ifc.state), M_PAUSE);
      ifc.door_closed = 1'b1; ifc.start = 1'b1; cyc(); ifc.start = 1'b0;
      chk("ft_done", 32'(ifc.state), M_DONE);
      ifc.stop = 1'b1; cyc(); ifc.stop = 1'b0;
      chk("ft_idle", 32'(ifc.state), M_IDLE);

      // Randomized traffic against the reference
      for (int i = 0; i < 1500; i++) begin
         ifc.load        = ($urandom_range(15) == 0);
         ifc.start       = ($urandom_range(3) == 0);
         ifc.stop        = ($urandom_range(40) == 0);
         ifc.door_closed = ($urandom_range(9) != 0);
         key_val         = int'($urandom_range(3, 1));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
